// File: rtl/cp_s1_ram_responder.sv
// Ping-pong RAM responder for the S1 m0 read / m1 write ports.
// Two banks of DEPTH words; each bank is handed over when its last address is accessed.
module cp_s1_ram_responder #(
  parameter int DELAY_DATA_ARRIVE = 2,
  parameter int READ_RAM_WIDTH    = 128,
  parameter int INIT_ADDR         = 0,
  parameter int END_ADDR          = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic [31:0]               i_m0_rd_addr,
  input  logic                      i_m0_rd_en,
  output logic [READ_RAM_WIDTH-1:0] o_m0_rd_data,
  output logic                      o_m0_rd_vld,
  input  logic [READ_RAM_WIDTH-1:0] i_m1_wr_data,
  input  logic [31:0]               i_m1_wr_addr,
  input  logic                      i_m1_wr_en,
  input  logic                      i_m1_wr_wea,
  output logic                      o_rd_frame_rdy,
  output logic                      o_wr_frame_rdy,
  output logic [1:0]                o_bank_sel,
  output logic [2:0]                o_err
);
  localparam int DEPTH = END_ADDR - INIT_ADDR;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W     = READ_RAM_WIDTH;

  logic [1:0]  bank_full_q, bank_full_d;
  logic        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [2:0]  err_q, err_d;
  logic        rd_frame_rdy_q, rd_frame_rdy_d, wr_frame_rdy_q, wr_frame_rdy_d;
  logic        rd_vld0_q, rd_ok0_q, rd_ok0_d, rd_bank0_q, rd_bank0_d;
  logic [31:0] rd_off_full, wr_off_full;
  logic [AW-1:0] rd_off, wr_off;
  logic        rd_in_range, wr_in_range, rd_ok, wr_ok, wr_req;
  logic [W-1:0] stage0_data;

  // Offsets wrap for addresses below INIT_ADDR, so one unsigned compare covers both bounds.
  always_comb begin
    rd_off_full = i_m0_rd_addr - 32'(INIT_ADDR);
    wr_off_full = i_m1_wr_addr - 32'(INIT_ADDR);
    rd_off      = rd_off_full[AW-1:0];
    wr_off      = wr_off_full[AW-1:0];
    rd_in_range = rd_off_full < 32'(DEPTH);
    wr_in_range = wr_off_full < 32'(DEPTH);
    wr_req      = i_m1_wr_en & i_m1_wr_wea;
    rd_ok       = i_m0_rd_en & rd_in_range & bank_full_q[rd_bank_q];
    wr_ok       = wr_req & wr_in_range & ~bank_full_q[wr_bank_q];
  end

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    err_d       = err_q | {(i_m0_rd_en & ~rd_in_range) | (wr_req & ~wr_in_range),
                           i_m0_rd_en & ~bank_full_q[rd_bank_q],
                           wr_req & bank_full_q[wr_bank_q]};
    if (wr_ok && wr_off_full == 32'(DEPTH - 1)) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end
    if (rd_ok && rd_off_full == 32'(DEPTH - 1)) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
    if (i_clear) begin
      bank_full_d = 2'b00;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      err_d       = 3'b000;
    end
    rd_frame_rdy_d = bank_full_q[rd_bank_q];
    wr_frame_rdy_d = ~bank_full_q[wr_bank_q];
    rd_ok0_d       = i_m0_rd_en ? rd_ok : rd_ok0_q;
    rd_bank0_d     = rd_ok ? rd_bank_q : rd_bank0_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q    <= 2'b00;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      err_q          <= 3'b000;
      rd_frame_rdy_q <= 1'b0;
      wr_frame_rdy_q <= 1'b1;
      rd_vld0_q      <= 1'b0;
      rd_ok0_q       <= 1'b0;
      rd_bank0_q     <= 1'b0;
    end else begin
      bank_full_q    <= bank_full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      err_q          <= err_d;
      rd_frame_rdy_q <= rd_frame_rdy_d;
      wr_frame_rdy_q <= wr_frame_rdy_d;
      rd_vld0_q      <= i_m0_rd_en;
      rd_ok0_q       <= rd_ok0_d;
      rd_bank0_q     <= rd_bank0_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [W-1:0] mem [DEPTH];
      logic [W-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (wr_ok && (wr_bank_q == 1'(gi))) mem[wr_off] <= i_m1_wr_data;
        if (rd_ok && (rd_bank_q == 1'(gi))) rdata_q <= mem[rd_off];
      end
    end
  endgenerate

  // Rejected reads still answer, with zero data, to keep fixed-latency capture aligned.
  assign stage0_data = rd_ok0_q ? (rd_bank0_q ? g_bank[1].rdata_q : g_bank[0].rdata_q) : '0;

  generate
    if (DELAY_DATA_ARRIVE == 1) begin : g_nopipe
      assign o_m0_rd_vld  = rd_vld0_q;
      assign o_m0_rd_data = stage0_data;
    end else begin : g_pipe
      localparam int NS = DELAY_DATA_ARRIVE - 1;
      logic         vld_q  [NS];
      logic         vld_d  [NS];
      logic [W-1:0] data_q [NS];
      logic [W-1:0] data_d [NS];

      always_comb begin
        vld_d[0]  = rd_vld0_q;
        data_d[0] = rd_vld0_q ? stage0_data : data_q[0];
        for (int k = 1; k < NS; k++) begin
          vld_d[k]  = vld_q[k-1];
          data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < NS; k++) begin
            vld_q[k]  <= 1'b0;
            data_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < NS; k++) begin
            vld_q[k]  <= vld_d[k];
            data_q[k] <= data_d[k];
          end
        end
      end

      assign o_m0_rd_vld  = vld_q[NS-1];
      assign o_m0_rd_data = data_q[NS-1];
    end
  endgenerate

  assign o_rd_frame_rdy = rd_frame_rdy_q;
  assign o_wr_frame_rdy = wr_frame_rdy_q;
  assign o_bank_sel     = {rd_bank_q, wr_bank_q};
  assign o_err          = err_q;
endmodule

// File: tb/tb_cp_s1_ram_responder.sv
// Directed bench for cp_s1_ram_responder: frame fill/drain, ping-pong, error flags, clear and reset.
module tb_cp_s1_ram_responder;
  localparam int D = 2;
  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_clear;
  logic [31:0]   i_m0_rd_addr;
  logic          i_m0_rd_en;
  logic [W-1:0]  o_m0_rd_data;
  logic          o_m0_rd_vld;
  logic [W-1:0]  i_m1_wr_data;
  logic [31:0]   i_m1_wr_addr;
  logic          i_m1_wr_en;
  logic          i_m1_wr_wea;
  logic          o_rd_frame_rdy;
  logic          o_wr_frame_rdy;
  logic [1:0]    o_bank_sel;
  logic [2:0]    o_err;

  int errors = 0;
  int checks = 0;

  // Expected-response history: entry D-1 is what must appear after the current edge.
  logic          hv [D];
  logic [W-1:0]  hd [D];
  logic [W-1:0]  last_d;

  always #5 clk = ~clk;

  cp_s1_ram_responder #(
    .DELAY_DATA_ARRIVE(D), .READ_RAM_WIDTH(W), .INIT_ADDR(0), .END_ADDR(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
    .i_m0_rd_addr(i_m0_rd_addr), .i_m0_rd_en(i_m0_rd_en),
    .o_m0_rd_data(o_m0_rd_data), .o_m0_rd_vld(o_m0_rd_vld),
    .i_m1_wr_data(i_m1_wr_data), .i_m1_wr_addr(i_m1_wr_addr),
    .i_m1_wr_en(i_m1_wr_en), .i_m1_wr_wea(i_m1_wr_wea),
    .o_rd_frame_rdy(o_rd_frame_rdy), .o_wr_frame_rdy(o_wr_frame_rdy),
    .o_bank_sel(o_bank_sel), .o_err(o_err)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_flush();
    for (int k = 0; k < D; k++) begin
      hv[k] = 1'b0;
      hd[k] = '0;
    end
    last_d = '0;
  endtask

  task automatic step(input logic rd_en, input logic [W-1:0] rd_exp);
    for (int k = D - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hd[k] = hd[k-1];
    end
    hv[0] = rd_en;
    hd[0] = rd_exp;
    @(posedge clk);
    #1;
    if (hv[D-1]) last_d = hd[D-1];
    check_eq("rd_vld", W'(o_m0_rd_vld), W'(hv[D-1]));
    check_eq("rd_data", o_m0_rd_data, last_d);
  endtask

  task automatic drive(input logic rd_en, input logic [31:0] ra, input logic [W-1:0] rexp,
                       input logic wr_en, input logic [31:0] wa, input logic [W-1:0] wd);
    i_m0_rd_en   = rd_en;
    i_m0_rd_addr = ra;
    i_m1_wr_en   = wr_en;
    i_m1_wr_wea  = wr_en;
    i_m1_wr_addr = wa;
    i_m1_wr_data = wd;
    step(rd_en, rexp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'd0, '0, 1'b0, 32'd0, '0);
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    idle(1);
    i_clear = 1'b0;
  endtask

  task automatic write_frame(input logic [W-1:0] base);
    for (int a = 0; a < 1024; a++) drive(1'b0, 32'd0, '0, 1'b1, 32'(a), base + W'(a));
  endtask

  task automatic check_status(input string tag, input logic [1:0] sel, input logic rrdy,
                              input logic wrdy, input logic [2:0] err);
    check_eq({tag, "/bank_sel"}, W'(o_bank_sel), W'(sel));
    check_eq({tag, "/rd_frame_rdy"}, W'(o_rd_frame_rdy), W'(rrdy));
    check_eq({tag, "/wr_frame_rdy"}, W'(o_wr_frame_rdy), W'(wrdy));
    check_eq({tag, "/err"}, W'(o_err), W'(err));
  endtask

  initial begin
    rst_n = 1'b0; i_clear = 1'b0;
    i_m0_rd_en = 1'b0; i_m0_rd_addr = '0;
    i_m1_wr_en = 1'b0; i_m1_wr_wea = 1'b0; i_m1_wr_addr = '0; i_m1_wr_data = '0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/rd_vld", W'(o_m0_rd_vld), '0);
    check_eq("reset/rd_data", o_m0_rd_data, '0);
    check_status("reset", 2'b00, 1'b0, 1'b1, 3'b000);
    rst_n = 1'b1;
    $display("txn reset released");

    // en without wea on the last address must neither store nor close the bank
    i_m1_wr_en = 1'b1; i_m1_wr_wea = 1'b0; i_m1_wr_addr = 32'd1023;
    step(1'b0, '0);
    idle(2);
    check_status("t1_wea0", 2'b00, 1'b0, 1'b1, 3'b000);

    write_frame('0);
    idle(2);
    check_status("t1_fill", 2'b01, 1'b1, 1'b1, 3'b000);
    $display("txn t1 write frame A into bank0");

    for (int a = 0; a < 1024; a++) drive(1'b1, 32'(a), W'(a), 1'b0, 32'd0, '0);
    idle(2);
    check_status("t2_drain", 2'b11, 1'b0, 1'b1, 3'b000);
    $display("txn t2 read frame A from bank0");

    pulse_clear();
    write_frame('0);
    for (int a = 0; a < 1024; a++)
      drive(1'b1, 32'(a), W'(a), 1'b1, 32'(a), W'(a) + W'(32'h1000));
    idle(2);
    check_status("t3_pingpong", 2'b10, 1'b1, 1'b1, 3'b000);
    for (int a = 0; a < 4; a++) drive(1'b1, 32'(a), W'(a) + W'(32'h1000), 1'b0, 32'd0, '0);
    idle(2);
    $display("txn t3 ping-pong frame B into bank1 while draining bank0");

    pulse_clear();
    idle(1);
    check_status("t4_clr", 2'b00, 1'b0, 1'b1, 3'b000);
    drive(1'b1, 32'd3, '0, 1'b0, 32'd0, '0);
    idle(2);
    check_eq("t4_underflow/err", W'(o_err), W'(3'b010));
    pulse_clear();
    check_eq("t4_cleared/err", W'(o_err), '0);
    $display("txn t4 underflow read and clear");

    write_frame(W'(32'h2000));
    write_frame(W'(32'h3000));
    idle(2);
    check_status("t5_full", 2'b00, 1'b1, 1'b0, 3'b000);
    drive(1'b0, 32'd0, '0, 1'b1, 32'd7, W'(32'hdead));
    idle(1);
    check_eq("t5_overflow/err", W'(o_err), W'(3'b001));
    drive(1'b1, 32'd7, W'(32'h2007), 1'b0, 32'd0, '0);
    idle(2);
    check_eq("t5_readback/err", W'(o_err), W'(3'b001));
    $display("txn t5 overflow write and readback");

    drive(1'b1, 32'd5000, '0, 1'b0, 32'd0, '0);
    idle(2);
    check_status("t6_rd_range", 2'b00, 1'b1, 1'b0, 3'b101);
    pulse_clear();
    idle(1);
    check_status("t6_clr", 2'b00, 1'b0, 1'b1, 3'b000);
    drive(1'b0, 32'd0, '0, 1'b1, 32'd1024, W'(1));
    idle(2);
    check_status("t6_wr_range", 2'b00, 1'b0, 1'b1, 3'b100);
    $display("txn t6 out-of-range accesses");

    for (int a = 0; a < 10; a++) drive(1'b0, 32'd0, '0, 1'b1, 32'(a), W'(a));
    drive(1'b1, 32'd0, '0, 1'b0, 32'd0, '0);
    rst_n = 1'b0;
    #1;
    model_flush();
    check_eq("t6_rst/rd_vld", W'(o_m0_rd_vld), '0);
    check_eq("t6_rst/rd_data", o_m0_rd_data, '0);
    check_status("t6_rst", 2'b00, 1'b0, 1'b1, 3'b000);
    #2;
    rst_n = 1'b1;
    idle(4);
    check_status("t6_after_rst", 2'b00, 1'b0, 1'b1, 3'b000);
    drive(1'b0, 32'd0, '0, 1'b1, 32'd1023, W'(5));
    idle(2);
    check_status("t6_close_after_rst", 2'b01, 1'b1, 1'b1, 3'b000);
    $display("txn t6 reset mid-frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
